// File: rtl/turkey_gun_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | turkey_gun_pkg: shared types and default constants for the gun controller. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package turkey_gun_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOW = 2'd1,
        FAST = 2'd2
    } axis_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        NEG  = 2'd1,
        POS  = 2'd2
    } dir_t;

    localparam int unsigned W_DEF           = 6;
    localparam int unsigned POS_MAX_DEF     = 63;
    localparam int unsigned POS_CENTER_DEF  = 32;
    localparam int unsigned SLOW_DIV_DEF    = 4;
    localparam int unsigned FAST_DIV_DEF    = 1;
    localparam int unsigned ACCEL_STEPS_DEF = 8;

endpackage
`default_nettype wire

// File: rtl/gun_axis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gun_axis: one crosshair axis with slow/fast ramp FSM and clamped position. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gun_axis
    import turkey_gun_pkg::*;
#(
    parameter int unsigned W           = W_DEF,
    parameter int unsigned POS_MAX     = POS_MAX_DEF,
    parameter int unsigned POS_CENTER  = POS_CENTER_DEF,
    parameter int unsigned SLOW_DIV    = SLOW_DIV_DEF,
    parameter int unsigned FAST_DIV    = FAST_DIV_DEF,
    parameter int unsigned ACCEL_STEPS = ACCEL_STEPS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_i,
    input  logic         center_i,
    input  logic         neg_i,
    input  logic         pos_i,
    output logic [W-1:0] pos_o,
    output logic         changed_o
);

    localparam int unsigned DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);
    localparam int unsigned STEP_W  = $clog2(ACCEL_STEPS + 1);

    axis_state_t        state_q, state_d;
    dir_t               dir_q, dir_d, dir_in;
    logic [DIV_W-1:0]   div_q, div_d, div_inc;
    logic [STEP_W-1:0]  steps_q, steps_d, steps_inc;
    logic [W-1:0]       pos_q, pos_d;
    logic               do_step;

    assign div_inc   = div_q + DIV_W'(1);
    assign steps_inc = steps_q + STEP_W'(1);

    always_comb begin
        if (neg_i && !pos_i)      dir_in = NEG;
        else if (pos_i && !neg_i) dir_in = POS;
        else                      dir_in = NONE;
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        div_d   = div_q;
        steps_d = steps_q;
        do_step = 1'b0;
        if (center_i) begin
            state_d = IDLE;
            dir_d   = NONE;
            div_d   = '0;
            steps_d = '0;
        end else if (tick_i) begin
            if (dir_in == NONE) begin
                state_d = IDLE;
                dir_d   = NONE;
                div_d   = '0;
                steps_d = '0;
            end else if (state_q == IDLE || dir_in != dir_q) begin
                // Fresh press or reversal: step at once and restart the ramp.
                do_step = 1'b1;
                dir_d   = dir_in;
                div_d   = '0;
                steps_d = STEP_W'(1);
                state_d = (state_q == IDLE && ACCEL_STEPS <= 1) ? FAST : SLOW;
            end else if (state_q == SLOW) begin
                if (div_inc == DIV_W'(SLOW_DIV)) begin
                    do_step = 1'b1;
                    div_d   = '0;
                    steps_d = steps_inc;
                    if (steps_inc >= STEP_W'(ACCEL_STEPS)) state_d = FAST;
                end else begin
                    div_d = div_inc;
                end
            end else begin
                if (div_inc == DIV_W'(FAST_DIV)) begin
                    do_step = 1'b1;
                    div_d   = '0;
                end else begin
                    div_d = div_inc;
                end
            end
        end
    end

    always_comb begin
        pos_d = pos_q;
        if (center_i) begin
            pos_d = W'(POS_CENTER);
        end else if (do_step) begin
            if (dir_d == NEG && pos_q != '0)                pos_d = pos_q - W'(1);
            else if (dir_d == POS && pos_q != W'(POS_MAX))  pos_d = pos_q + W'(1);
        end
    end

    assign changed_o = !center_i && (pos_d != pos_q);
    assign pos_o     = pos_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= NONE;
            div_q   <= '0;
            steps_q <= '0;
            pos_q   <= W'(POS_CENTER);
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            div_q   <= div_d;
            steps_q <= steps_d;
            pos_q   <= pos_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/turkey_gun_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | turkey_gun_ctrl: joystick to 6-bit gun crosshair, paced by the 4 ms tick.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module turkey_gun_ctrl
    import turkey_gun_pkg::*;
#(
    parameter int unsigned W           = W_DEF,
    parameter int unsigned POS_MAX     = POS_MAX_DEF,
    parameter int unsigned POS_CENTER  = POS_CENTER_DEF,
    parameter int unsigned SLOW_DIV    = SLOW_DIV_DEF,
    parameter int unsigned FAST_DIV    = FAST_DIV_DEF,
    parameter int unsigned ACCEL_STEPS = ACCEL_STEPS_DEF
) (
    input  logic         clock_12,
    input  logic         reset,
    input  logic         tick_4ms,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_center,
    output logic [W-1:0] gun_h,
    output logic [W-1:0] gun_v,
    output logic         step_strobe
);

    logic tick_q;
    logic tick_edge;
    logic changed_h, changed_v;
    logic strobe_q;

    // tick_q resets high so a tick already asserted at release is not an edge.
    assign tick_edge = tick_4ms & ~tick_q;

    gun_axis #(
        .W(W), .POS_MAX(POS_MAX), .POS_CENTER(POS_CENTER),
        .SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV), .ACCEL_STEPS(ACCEL_STEPS)
    ) u_axis_h (
        .clk       (clock_12),
        .rst       (reset),
        .tick_i    (tick_edge),
        .center_i  (btn_center),
        .neg_i     (btn_left),
        .pos_i     (btn_right),
        .pos_o     (gun_h),
        .changed_o (changed_h)
    );

    gun_axis #(
        .W(W), .POS_MAX(POS_MAX), .POS_CENTER(POS_CENTER),
        .SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV), .ACCEL_STEPS(ACCEL_STEPS)
    ) u_axis_v (
        .clk       (clock_12),
        .rst       (reset),
        .tick_i    (tick_edge),
        .center_i  (btn_center),
        .neg_i     (btn_up),
        .pos_i     (btn_down),
        .pos_o     (gun_v),
        .changed_o (changed_v)
    );

    always_ff @(posedge clock_12) begin
        if (reset) begin
            tick_q   <= 1'b1;
            strobe_q <= 1'b0;
        end else begin
            tick_q   <= tick_4ms;
            strobe_q <= changed_h | changed_v;
        end
    end

    assign step_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_turkey_gun_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_turkey_gun_ctrl: directed self-checking bench for turkey_gun_ctrl.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_turkey_gun_ctrl;

    logic       clk = 1'b0;
    logic       reset, tick_4ms;
    logic       btn_left, btn_right, btn_up, btn_down, btn_center;
    logic [5:0] gun_h, gun_v;
    logic       step_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    turkey_gun_ctrl dut (
        .clock_12    (clk),
        .reset       (reset),
        .tick_4ms    (tick_4ms),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_center  (btn_center),
        .gun_h       (gun_h),
        .gun_v       (gun_v),
        .step_strobe (step_strobe)
    );

    // Entered at posedge+1 with tick low; returns at posedge+1 just after the edge cycle.
    task automatic do_tick();
        @(posedge clk); #1;
        tick_4ms = 1'b1;
        @(posedge clk); #1;
        tick_4ms = 1'b0;
    endtask

    task automatic do_center();
        btn_center = 1'b1;
        @(posedge clk); #1;
        btn_center = 1'b0;
    endtask

    task automatic release_all();
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick_4ms = 1'b1; btn_center = 1'b0;
        release_all();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (gun_h !== 6'd32) begin n_fail++; $display("FAIL reset_h: got %0d want 32", gun_h); end
        n_checks++;
        if (gun_v !== 6'd32) begin n_fail++; $display("FAIL reset_v: got %0d want 32", gun_v); end
        n_checks++;
        if (step_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b want 0", step_strobe); end
        tick_4ms = 1'b0;
    endtask

    task automatic test_ramp_right();
        int exp_h, prev_h;
        prev_h = 32;
        btn_right = 1'b1;
        for (int e = 1; e <= 54; e++) begin
            do_tick();
            if (e <= 29) exp_h = 32 + (e - 1) / 4 + 1;
            else         exp_h = (40 + e - 29 > 63) ? 63 : 40 + e - 29;
            n_checks++;
            if (gun_h !== 6'(exp_h)) begin
                n_fail++; $display("FAIL ramp_h edge %0d: got %0d want %0d", e, gun_h, exp_h);
            end
            n_checks++;
            if (step_strobe !== (exp_h != prev_h)) begin
                n_fail++; $display("FAIL ramp_strobe edge %0d: got %b want %b", e, step_strobe, exp_h != prev_h);
            end
            prev_h = exp_h;
        end
        n_checks++;
        if (gun_v !== 6'd32) begin n_fail++; $display("FAIL ramp_v: got %0d want 32", gun_v); end
        @(posedge clk); #1;
        n_checks++;
        if (step_strobe !== 1'b0) begin n_fail++; $display("FAIL strobe_width: got %b want 0", step_strobe); end
        release_all();
        do_center();
    endtask

    task automatic test_conflict_diag();
        btn_left = 1'b1; btn_right = 1'b1;
        do_tick();
        n_checks++;
        if (gun_h !== 6'd32 || step_strobe !== 1'b0) begin
            n_fail++; $display("FAIL both_lr: got h=%0d s=%b want h=32 s=0", gun_h, step_strobe);
        end
        btn_left = 1'b0;
        do_tick();
        n_checks++;
        if (gun_h !== 6'd33) begin n_fail++; $display("FAIL after_both_idle: got %0d want 33", gun_h); end
        release_all();
        do_center();
        btn_up = 1'b1; btn_right = 1'b1;
        do_tick();
        n_checks++;
        if (gun_h !== 6'd33 || gun_v !== 6'd31 || step_strobe !== 1'b1) begin
            n_fail++; $display("FAIL diag: got h=%0d v=%0d s=%b want h=33 v=31 s=1", gun_h, gun_v, step_strobe);
        end
        release_all();
        do_center();
    endtask

    task automatic test_reverse();
        logic [5:0] exp_rev [5];
        exp_rev = '{6'd49, 6'd49, 6'd49, 6'd49, 6'd48};
        btn_right = 1'b1;
        repeat (39) do_tick();
        n_checks++;
        if (gun_h !== 6'd50) begin n_fail++; $display("FAIL fast_reach50: got %0d want 50", gun_h); end
        btn_right = 1'b0; btn_left = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_tick();
            n_checks++;
            if (gun_h !== exp_rev[i]) begin
                n_fail++; $display("FAIL reverse edge %0d: got %0d want %0d", i, gun_h, exp_rev[i]);
            end
        end
        release_all();
        do_center();
    endtask

    task automatic test_center();
        btn_left = 1'b1; btn_down = 1'b1;
        repeat (43) do_tick();
        btn_left = 1'b0;
        repeat (6) do_tick();
        n_checks++;
        if (gun_h !== 6'd10 || gun_v !== 6'd60) begin
            n_fail++; $display("FAIL reach_10_60: got h=%0d v=%0d want h=10 v=60", gun_h, gun_v);
        end
        btn_center = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (gun_h !== 6'd32 || gun_v !== 6'd32 || step_strobe !== 1'b0) begin
            n_fail++; $display("FAIL center_between: got h=%0d v=%0d s=%b want 32 32 0", gun_h, gun_v, step_strobe);
        end
        btn_down = 1'b0; btn_right = 1'b1;
        do_tick();
        n_checks++;
        if (gun_h !== 6'd32 || gun_v !== 6'd32 || step_strobe !== 1'b0) begin
            n_fail++; $display("FAIL center_on_tick: got h=%0d v=%0d s=%b want 32 32 0", gun_h, gun_v, step_strobe);
        end
        btn_center = 1'b0;
        do_tick();
        n_checks++;
        if (gun_h !== 6'd33 || step_strobe !== 1'b1) begin
            n_fail++; $display("FAIL center_then_idle: got h=%0d s=%b want 33 1", gun_h, step_strobe);
        end
        release_all();
    endtask

    task automatic test_reset_mid();
        btn_left = 1'b1;
        repeat (3) do_tick();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if (gun_h !== 6'd32 || step_strobe !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got h=%0d s=%b want 32 0", gun_h, step_strobe);
        end
        release_all();
    endtask

    initial begin
        test_reset();
        test_ramp_right();
        test_conflict_diag();
        test_reverse();
        test_center();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
